// File: rtl/bitstream_pkg.sv
// Shared constants and state type for the bitstream packer/reader pair.
// The reader uses them to size its buffer and fill-level logic.
package bitstream_pkg;

  localparam int IN_W  = 32;
  localparam int BUF_W = 2 * IN_W;
  localparam int LEN_W = 6;
  localparam int LVL_W = 7;

  typedef enum logic {
    STREAM = 1'b0,
    DRAIN  = 1'b1
  } rd_state_t;

endpackage

// File: rtl/bitstream_reader_if.sv
// Bundles the word-input and field-consume handshakes of the bitstream reader.
// master = DMA/decoder side, slave = the reader itself.
interface bitstream_reader_if;
  import bitstream_pkg::*;

  logic [IN_W-1:0]  in_data;
  logic [LEN_W-1:0] in_bits;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  peek_data;
  logic [LVL_W-1:0] avail_bits;
  logic             consume;
  logic [LEN_W-1:0] consume_len;
  logic             done;
  logic             err;

  modport master (
    output in_data, in_bits, in_last, in_valid, consume, consume_len,
    input  in_ready, peek_data, avail_bits, done, err
  );

  modport slave (
    input  in_data, in_bits, in_last, in_valid, consume, consume_len,
    output in_ready, peek_data, avail_bits, done, err
  );

endinterface

// File: rtl/bit_align_shifter.sv
// Masks an LSB-justified word to its valid bits and drops it into a 64-bit
// field so that its MSB lands just below the first offset_i occupied bits.
module bit_align_shifter
  import bitstream_pkg::*;
(
  input  logic [IN_W-1:0]  data_i,
  input  logic [LEN_W-1:0] bits_i,
  input  logic [LVL_W-1:0] offset_i,
  output logic [BUF_W-1:0] field_o
);

  logic [BUF_W-1:0] mask;
  logic [BUF_W-1:0] masked;
  logic [LVL_W-1:0] leftShift;

  // Left-justify the valid bits at bit 63, then slide them down past the
  // bits already in the buffer; every bit outside the field stays zero.
  always_comb begin
    mask      = (BUF_W'(1) << bits_i) - BUF_W'(1);
    masked    = {{(BUF_W-IN_W){1'b0}}, data_i} & mask;
    leftShift = LVL_W'(BUF_W) - LVL_W'(bits_i);
    field_o   = (masked << leftShift) >> offset_i;
  end

endmodule

// File: rtl/bitstream_reader.sv
// Variable-length field extractor: packs 1..32-bit words MSB-first into a
// 64-bit buffer and lets the decoder peek and consume 0..32 bits per cycle.
module bitstream_reader
  import bitstream_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  bitstream_reader_if.slave  bus
);

  rd_state_t        state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic             acceptWord;
  logic             consumeOk;
  logic             bitsOk;
  logic [LVL_W-1:0] consumeLvl;
  logic [BUF_W-1:0] shiftedBuf;
  logic [BUF_W-1:0] placedField;

  // Ready depends only on registered state so the DMA never sees a path from consume.
  assign bus.in_ready = !reset && (state_q == STREAM) && (level_q <= LVL_W'(IN_W));

  assign acceptWord = bus.in_valid && bus.in_ready;
  assign consumeOk  = bus.consume
                      && ({1'b0, bus.consume_len} <= level_q)
                      && (bus.consume_len <= LEN_W'(IN_W));
  assign bitsOk     = (bus.in_bits != '0) && (bus.in_bits <= LEN_W'(IN_W));

  // Consume happens first; the incoming word is placed after the post-consume level.
  assign consumeLvl = consumeOk ? (level_q - LVL_W'(bus.consume_len)) : level_q;
  assign shiftedBuf = consumeOk ? (buf_q << bus.consume_len) : buf_q;

  bit_align_shifter u_align (
    .data_i   (bus.in_data),
    .bits_i   (bus.in_bits),
    .offset_i (consumeLvl),
    .field_o  (placedField)
  );

  always_comb begin
    buf_d   = shiftedBuf;
    level_d = consumeLvl;
    err_d   = err_q;
    state_d = state_q;
    done_d  = 1'b0;

    if (bus.consume && !consumeOk) begin
      err_d = 1'b1;
    end

    if (acceptWord) begin
      if (bitsOk) begin
        buf_d   = shiftedBuf | placedField;
        level_d = consumeLvl + LVL_W'(bus.in_bits);
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      STREAM: begin
        if (acceptWord && bus.in_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (level_d == '0) begin
          state_d = STREAM;
          done_d  = 1'b1;
        end
      end
      default: state_d = STREAM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STREAM;
      buf_q   <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      level_q <= level_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bus.peek_data  = buf_q[BUF_W-1 -: IN_W];
  assign bus.avail_bits = level_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_bitstream_reader.sv
// Directed and randomized checks of bitstream_reader against a bit-queue model.
module tb_bitstream_reader;
  import bitstream_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bitstream_reader_if bus();

  bitstream_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: stream bits oldest-first, plus drain/done/error flags.
  bit mq[$];
  bit mDrain = 1'b0;
  bit mErr   = 1'b0;
  bit mDone  = 1'b0;

  logic [31:0] rData [1000];
  int          rLen  [1000];

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelPeek();
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < 32; i++)
      if (i < mq.size()) p[31-i] = mq[i];
    return p;
  endfunction

  function automatic logic [31:0] fieldMask(input int len);
    logic [32:0] m;
    m = (33'd1 << len) - 33'd1;
    return m[31:0];
  endfunction

  task automatic modelReset();
    mq.delete();
    mDrain = 1'b0;
    mErr   = 1'b0;
    mDone  = 1'b0;
  endtask

  task automatic modelStep(input logic v, input logic [31:0] d, input int b,
                           input logic l, input logic c, input int cl);
    bit wasDrain;
    bit ready;
    wasDrain = mDrain;
    ready    = !mDrain && (mq.size() <= 32);
    mDone    = 1'b0;
    if (c) begin
      if (cl <= mq.size() && cl <= 32) begin
        repeat (cl) void'(mq.pop_front());
      end else begin
        mErr = 1'b1;
      end
    end
    if (v && ready) begin
      if (b >= 1 && b <= 32) begin
        for (int i = b - 1; i >= 0; i--) mq.push_back(d[i]);
      end else begin
        mErr = 1'b1;
      end
      if (l) mDrain = 1'b1;
    end
    if (wasDrain && mq.size() == 0) begin
      mDrain = 1'b0;
      mDone  = 1'b1;
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "/peek"},  bus.peek_data, modelPeek());
    checkVal({tag, "/avail"}, 32'(bus.avail_bits), 32'(mq.size()));
    checkVal({tag, "/ready"}, 32'(bus.in_ready),
             32'(!reset && !mDrain && (mq.size() <= 32)));
    checkVal({tag, "/done"},  32'(bus.done), 32'(mDone));
    checkVal({tag, "/err"},   32'(bus.err),  32'(mErr));
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input int b,
                               input logic l, input logic c, input int cl,
                               input string tag);
    @(negedge clk);
    bus.in_valid    = v;
    bus.in_data     = d;
    bus.in_bits     = 6'(b);
    bus.in_last     = l;
    bus.consume     = c;
    bus.consume_len = 6'(cl);
    @(posedge clk);
    modelStep(v, d, b, l, c, cl);
    #1;
    checkOutput(tag);
  endtask

  task automatic applyReset(input int n);
    @(negedge clk);
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_bits     = '0;
    bus.in_last     = 1'b0;
    bus.consume     = 1'b0;
    bus.consume_len = '0;
    repeat (n) @(posedge clk);
    modelReset();
    #1;
    checkOutput("inReset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("afterReset");
  endtask

  initial begin
    int wi, ci, cyc, doneCount;
    logic        cv, vv;
    int          cl;

    applyReset(2);

    applyStimulus(1, 32'hDEADBEEF, 32, 0, 0, 0, "word32");
    checkVal("deadbeefPeek", bus.peek_data, 32'hDEADBEEF);
    checkVal("deadbeefAvail", 32'(bus.avail_bits), 32'd32);
    applyStimulus(0, 0, 0, 0, 1, 32, "drain32");

    applyStimulus(1, 32'h5, 3, 0, 0, 0, "w3");
    applyStimulus(1, 32'h1, 1, 0, 0, 0, "w1");
    checkVal("packPeek", bus.peek_data, 32'hB0000000);
    checkVal("packAvail", 32'(bus.avail_bits), 32'd4);
    applyStimulus(0, 0, 0, 0, 1, 4, "drain4");

    applyStimulus(1, $urandom, 32, 0, 0, 0, "fillA");
    applyStimulus(1, $urandom, 32, 0, 0, 0, "fillB");
    checkVal("fullAvail", 32'(bus.avail_bits), 32'd64);
    checkVal("fullReady", 32'(bus.in_ready), 32'd0);
    applyStimulus(1, $urandom, 32, 0, 0, 0, "blockedFull");
    applyStimulus(1, $urandom, 32, 0, 1, 32, "consAt64");
    applyStimulus(1, $urandom, 32, 0, 1, 32, "consAcc32");
    applyStimulus(0, 0, 0, 0, 1, 32, "empty");

    applyStimulus(1, 32'hFFFFFF15, 5, 0, 0, 0, "lvl5");
    applyStimulus(0, 0, 0, 0, 1, 6, "overCons");
    checkVal("overErr", 32'(bus.err), 32'd1);
    checkVal("overAvail", 32'(bus.avail_bits), 32'd5);
    checkVal("overPeek", bus.peek_data, 32'hA8000000);
    applyStimulus(0, 0, 0, 0, 1, 5, "cons5");
    checkVal("cons5Avail", 32'(bus.avail_bits), 32'd0);

    applyReset(1);
    applyStimulus(1, 32'hFF, 40, 0, 0, 0, "badBits");
    checkVal("badBitsErr", 32'(bus.err), 32'd1);

    applyReset(1);
    applyStimulus(1, $urandom, 30, 0, 0, 0, "pre30");
    applyStimulus(1, 32'h3, 2, 1, 0, 0, "lastWord");
    checkVal("lastReady", 32'(bus.in_ready), 32'd0);
    applyStimulus(1, $urandom, 8, 0, 0, 0, "drainIdle");
    applyStimulus(0, 0, 0, 0, 1, 32, "finalCons");
    checkVal("finalDone", 32'(bus.done), 32'd1);
    checkVal("finalReady", 32'(bus.in_ready), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, "afterDone");
    checkVal("doneOnce", 32'(bus.done), 32'd0);

    applyStimulus(1, 32'hAB, 0, 1, 0, 0, "emptyLast");
    applyStimulus(0, 0, 0, 0, 1, 0, "zeroCons");
    checkVal("zeroDone", 32'(bus.done), 32'd1);

    applyReset(1);
    applyStimulus(1, $urandom, 8, 1, 0, 0, "drainBeforeReset");
    applyReset(1);
    checkVal("resetNoDone", 32'(bus.done), 32'd0);

    for (int i = 0; i < 1000; i++) begin
      rData[i] = $urandom;
      rLen[i]  = $urandom_range(1, 32);
    end
    wi = 0;
    ci = 0;
    cyc = 0;
    doneCount = 0;
    while (ci < 1000 && cyc < 6000) begin
      vv = (wi < 1000) && (($urandom_range(0, 3)) != 0);
      cv = (mq.size() >= rLen[ci]) && (($urandom_range(0, 3)) != 0);
      cl = cv ? rLen[ci] : 0;
      if (cv) begin
        checkVal("randField", bus.peek_data >> (32 - rLen[ci]), rData[ci] & fieldMask(rLen[ci]));
      end
      if (vv && !mDrain && mq.size() <= 32) begin
        applyStimulus(1, rData[wi], rLen[wi], wi == 999, cv, cl, "rand");
        wi++;
      end else begin
        applyStimulus(vv, (wi < 1000) ? rData[wi] : 32'h0, (wi < 1000) ? rLen[wi] : 1,
                      wi == 999, cv, cl, "rand");
      end
      if (cv) ci++;
      if (bus.done) doneCount++;
      cyc++;
    end
    checkVal("randComplete", 32'(ci), 32'd1000);
    applyStimulus(0, 0, 0, 0, 0, 0, "randTail");
    checkVal("randDoneCount", 32'(doneCount), 32'd1);
    checkVal("randNoErr", 32'(bus.err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
